// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt/trap sequencer.
package intr_pkg;

  // Sequencer states. TAKE and RET each last exactly one cycle.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    TAKE    = 3'd2,
    HANDLER = 3'd3,
    RET     = 3'd4
  } intr_state_t;

  // Value driven on redirect_pc whenever no redirect is in progress.
  localparam logic [31:0] RESET_PC = 32'h0;

  // True for the states that redirect the PC and hold off fetch.
  function automatic logic is_redirect(input intr_state_t s);
    return (s == TAKE) || (s == RET);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Brings the asynchronous interrupt line into the clk domain through a
// flop chain, then turns it into a request: a one-cycle pulse on each
// rising edge (EDGE_TRIG=1) or the synchronised level (EDGE_TRIG=0).
// SYNC_STAGES must lie in 2..4.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic irq_req
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift irq_in through the synchroniser and remember the last synced value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge mode fires only when the synced line goes 0 -> 1.
  always_comb begin
    if (EDGE_TRIG) irq_req = sync_q[SYNC_STAGES-1] & ~prev_q;
    else           irq_req = sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt/trap sequencer for the multicycle core. Latches a synchronised
// interrupt request, takes it only at an instruction boundary while the CSR
// block reports it enabled, and sequences trap entry (redirect to mtvec)
// and mret (redirect to mepc). Outputs are decoded from registered state
// and forced to 0 while rst is high so no strobe escapes during reset.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_in,
  input  logic        csr_mie,
  input  logic        csr_mstatus,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        instr_boundary,
  input  logic        mret_exec,
  output logic        int_taken,
  output logic        int_ret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cpu_hold,
  output logic        irq_pending,
  output logic        in_handler
);

  logic        irq_req;
  logic        take_ok;
  intr_state_t state_q, state_d;
  logic        pending_q, pending_d;
  logic        taken_q, ret_q, handler_q, redirect_q;

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TRIG   (EDGE_TRIG)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .irq_req (irq_req)
  );

  assign take_ok = pending_q & csr_mie & csr_mstatus & instr_boundary;

  // Next-state logic; mret always wins over taking a pending interrupt.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mret_exec)      state_d = RET;
        else if (pending_q) state_d = PENDING;
      end
      PENDING: begin
        if (mret_exec)      state_d = RET;
        else if (take_ok)   state_d = TAKE;
      end
      TAKE:                 state_d = HANDLER;
      HANDLER: begin
        if (mret_exec)      state_d = RET;
      end
      RET:                  state_d = pending_q ? PENDING : IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Pending clears only when entering TAKE; a coincident new request survives.
  always_comb begin
    pending_d = irq_req | (pending_q & ~((state_q == PENDING) && (state_d == TAKE)));
  end

  // State, pending flag and output flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      taken_q    <= 1'b0;
      ret_q      <= 1'b0;
      handler_q  <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      taken_q    <= (state_d == TAKE);
      ret_q      <= (state_d == RET);
      handler_q  <= (state_d == HANDLER);
      redirect_q <= is_redirect(state_d);
    end
  end

  // Output decode; reset masks everything in the cycle it is asserted.
  always_comb begin
    int_taken      = taken_q & ~rst;
    int_ret        = ret_q & ~rst;
    redirect_valid = redirect_q & ~rst;
    cpu_hold       = redirect_q & ~rst;
    irq_pending    = pending_q & ~rst;
    in_handler     = handler_q & ~rst;
    redirect_pc    = RESET_PC;
    if (!rst) begin
      if (taken_q)    redirect_pc = csr_mtvec;
      else if (ret_q) redirect_pc = csr_mepc;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl. A cycle model built from the
// sequencer's behaviour predicts every output each cycle; the prediction
// is queued when the stimulus is applied and popped when the DUT is sampled.
module tb_intr_ctrl;

  localparam int S        = 2;
  localparam bit EDGE     = 1'b1;
  localparam int M_IDLE   = 0;
  localparam int M_PEND   = 1;
  localparam int M_TAKE   = 2;
  localparam int M_HAND   = 3;
  localparam int M_RET    = 4;

  // clock / reset block
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_in = 1'b0;
  logic        csr_mie = 1'b0;
  logic        csr_mstatus = 1'b0;
  logic [31:0] csr_mtvec = 32'h0000_0100;
  logic [31:0] csr_mepc = 32'h0000_0234;
  logic        instr_boundary = 1'b0;
  logic        mret_exec = 1'b0;
  logic        int_taken, int_ret, redirect_valid, cpu_hold, irq_pending, in_handler;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  intr_ctrl #(.SYNC_STAGES(S), .EDGE_TRIG(EDGE)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .csr_mie        (csr_mie),
    .csr_mstatus    (csr_mstatus),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .instr_boundary (instr_boundary),
    .mret_exec      (mret_exec),
    .int_taken      (int_taken),
    .int_ret        (int_ret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .cpu_hold       (cpu_hold),
    .irq_pending    (irq_pending),
    .in_handler     (in_handler)
  );

  // scoreboard state
  logic [37:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          taken_cnt = 0;

  // reference model state
  int          m_state = M_IDLE;
  logic        m_pend  = 1'b0;
  logic [S:0]  m_hist  = '0;   // m_hist[i] = irq_in sampled i+1 edges ago

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Expected outputs for the current cycle: {taken, ret, rv, hold, pend, hand, pc}.
  function automatic logic [37:0] model_out(input logic r);
    logic        tk, rt;
    logic [31:0] pc;
    if (r) return '0;
    tk = (m_state == M_TAKE);
    rt = (m_state == M_RET);
    pc = tk ? csr_mtvec : (rt ? csr_mepc : 32'h0);
    return {tk, rt, tk | rt, tk | rt, m_pend, (m_state == M_HAND), pc};
  endfunction

  // Advance the model across one rising edge using the inputs just applied.
  task automatic model_edge();
    logic req, tok;
    int   nxt;
    if (rst) begin
      m_state = M_IDLE;
      m_pend  = 1'b0;
      m_hist  = '0;
      return;
    end
    req = EDGE ? (m_hist[S-1] & ~m_hist[S]) : m_hist[S-1];
    tok = m_pend & csr_mie & csr_mstatus & instr_boundary;
    nxt = m_state;
    case (m_state)
      M_IDLE: nxt = mret_exec ? M_RET : (m_pend ? M_PEND : M_IDLE);
      M_PEND: nxt = mret_exec ? M_RET : (tok ? M_TAKE : M_PEND);
      M_TAKE: nxt = M_HAND;
      M_HAND: nxt = mret_exec ? M_RET : M_HAND;
      M_RET:  nxt = m_pend ? M_PEND : M_IDLE;
      default: nxt = M_IDLE;
    endcase
    if (nxt == M_TAKE) m_pend = req;
    else               m_pend = m_pend | req;
    m_state = nxt;
    m_hist  = {m_hist[S-1:0], irq_in};
  endtask

  // driver: apply one cycle of stimulus, check the DUT, cross the edge
  task automatic step(input logic r, input logic irq, input logic bnd, input logic mret);
    logic [37:0] e;
    rst            = r;
    irq_in         = irq;
    instr_boundary = bnd;
    mret_exec      = mret;
    exp_q.push_back(model_out(r));
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("int_taken",      {31'd0, int_taken},      {31'd0, e[37]});
      check_eq("int_ret",        {31'd0, int_ret},        {31'd0, e[36]});
      check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, e[35]});
      check_eq("cpu_hold",       {31'd0, cpu_hold},       {31'd0, e[34]});
      check_eq("irq_pending",    {31'd0, irq_pending},    {31'd0, e[33]});
      check_eq("in_handler",     {31'd0, in_handler},     {31'd0, e[32]});
      check_eq("redirect_pc",    redirect_pc,             e[31:0]);
    end
    if (int_taken === 1'b1) taken_cnt++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // one-cycle irq pulse, then enough cycles for the sequencer to reach PENDING
  task automatic raise_irq();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(S + 2);
  endtask

  initial begin
    csr_mie     = 1'b1;
    csr_mstatus = 1'b1;

    // Reset held 3 cycles with irq high, then latency to pending and a basic take.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < S + 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);      // boundary in PENDING -> TAKE
    step(1'b0, 1'b0, 1'b0, 1'b0);      // TAKE cycle
    idle(2);                           // HANDLER, pending cleared
    step(1'b0, 1'b0, 1'b0, 1'b1);      // mret
    idle(2);

    // Masked request: five boundaries with mie=0, then unmask.
    csr_mie = 1'b0;
    raise_irq();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    csr_mie = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Return with a request queued from inside the handler.
    raise_irq();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    raise_irq();                       // latches while in HANDLER, not taken
    csr_mepc = 32'h0000_0234;
    step(1'b0, 1'b0, 1'b1, 1'b1);      // mret (boundary ignored in HANDLER)
    step(1'b0, 1'b0, 1'b0, 1'b0);      // RET cycle -> PENDING
    step(1'b0, 1'b0, 1'b1, 1'b0);      // take the queued request
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Collision: mret and take_ok together in PENDING.
    raise_irq();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);      // RET cycle
    step(1'b0, 1'b0, 1'b1, 1'b0);      // later boundary -> TAKE
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    check_eq("directed_take_count", taken_cnt, 32'd5);

    // Reset asserted in the TAKE cycle.
    raise_irq();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);      // would be TAKE; masked by reset
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        csr_mie     = ($urandom_range(0, 3) != 0);
        csr_mstatus = ($urandom_range(0, 3) != 0);
      end
      csr_mtvec = $urandom();
      csr_mepc  = $urandom();
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt/trap sequencer for the multicycle RISC-V core.
- Synchronises the external interrupt line and holds the request pending.
- Takes the interrupt only at an instruction boundary, and only when the CSR block reports interrupts enabled (mie) and globally enabled (mstatus).
- Drives the CSR block's trap-entry/return strobes, and the PC redirect to mtvec (trap) or mepc (mret).

Parameters:
- SYNC_STAGES, 2: number of flops in the irq_in synchroniser; legal range 2..4.
- EDGE_TRIG, 1: 1 = a rising edge of the synchronised irq sets pending; 0 = a high level sets pending.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- irq_in  in  1  external interrupt request, asynchronous to clk
- csr_mie  in  1  interrupt enable bit from the CSR block
- csr_mstatus  in  1  global enable bit from the CSR block
- csr_mtvec  in  32  trap handler address
- csr_mepc  in  32  trap return address
- instr_boundary  in  1  one-cycle pulse from the control FSM; the current instruction has retired
- mret_exec  in  1  one-cycle pulse; an mret is executing
- int_taken  out  1  one-cycle trap-entry strobe to the CSR block
- int_ret  out  1  one-cycle trap-return strobe to the CSR block
- redirect_valid  out  1  PC register must load redirect_pc this cycle
- redirect_pc  out  32  redirect target
- cpu_hold  out  1  control FSM must not start a fetch this cycle
- irq_pending  out  1  a latched request is outstanding
- in_handler  out  1  the core is executing the trap handler

Behaviour:
- Reset: state=IDLE; synchroniser flops, edge-detect flop and pending flag all 0. Every output is 0, including redirect_pc=0. Reset mid-operation aborts any TAKE/RET; no strobe is emitted in the reset cycle.
- Synchroniser latency: irq_in is first sampled high at edge k; with EDGE_TRIG=1, irq_pending is 1 after edge k+SYNC_STAGES.
- Pending flag:
  - Set by a sync edge (or level) in any state.
  - Cleared only on the transition into TAKE.
  - If set and clear coincide, set wins: the new request stays pending.
- take_ok = irq_pending & csr_mie & csr_mstatus & instr_boundary.
- States:
  - IDLE: irq_pending=1 -> PENDING; mret_exec -> RET.
  - PENDING: mret_exec -> RET (priority over take); else take_ok -> TAKE; else stay.
  - TAKE, exactly one cycle: int_taken=1, redirect_valid=1, redirect_pc=csr_mtvec, cpu_hold=1. Next state HANDLER.
  - HANDLER: in_handler=1. New requests latch into pending but are never taken here. mret_exec -> RET.
  - RET, exactly one cycle: int_ret=1, redirect_valid=1, redirect_pc=csr_mepc, cpu_hold=1. Next state PENDING if irq_pending, else IDLE.
- Outputs are Moore, decoded from state. int_taken and int_ret are never high together. In IDLE/PENDING/HANDLER: redirect_valid=0, cpu_hold=0, redirect_pc=0.
- Trap-entry handshake: the CSR block samples int_taken at the TAKE->HANDLER edge, saves mepc and clears mstatus. csr_mtvec is read combinationally during TAKE.
- A take cannot recur before return: csr_mstatus is 0 after trap entry, and HANDLER ignores take_ok. An mret with no trap active still performs RET to csr_mepc.
- Simultaneous events:
  - mret_exec and take_ok in the same cycle: RET first; the interrupt stays pending.
  - instr_boundary is ignored outside PENDING.

Decomposition:
- Package intr_pkg: intr_state_t enum {IDLE, PENDING, TAKE, HANDLER, RET}; localparam RESET_PC=32'h0.
- Sub-module irq_sync_edge (parameters SYNC_STAGES, EDGE_TRIG): the synchroniser flop chain plus edge-detect register; output irq_req, a one-cycle pulse (edge mode) or a level (level mode).
- The FSM and pending flag stay in intr_ctrl.

Test Plan:
- Reset: hold rst 3 cycles with irq_in=1 -> all outputs 0 during reset; after release, irq_pending=1 exactly SYNC_STAGES edges after the first sample of irq_in.
- Basic take: mie=1, mstatus=1, mtvec=32'h0000_0100, irq rising edge, then instr_boundary pulse -> next cycle int_taken=1, redirect_valid=1, redirect_pc=32'h100, cpu_hold=1 for exactly 1 cycle; then in_handler=1 and irq_pending=0.
- Masked: mie=0, irq edge, 5 boundaries -> no int_taken and irq_pending stays 1. Set mie=1, next boundary -> TAKE.
- Return with a request queued: in HANDLER, pulse irq, then mret_exec with mepc=32'h0000_0234 -> int_ret=1 with redirect_pc=32'h234 for 1 cycle; state becomes PENDING; the next boundary with mstatus=1 causes TAKE.
- Collision: in PENDING, mret_exec and take_ok in the same cycle -> RET cycle first (int_ret=1, int_taken=0); TAKE follows at a later boundary.
- Reset during TAKE: assert rst in the TAKE cycle -> int_taken=0 in that cycle and the following one; state IDLE; pending cleared.
